mux_addsub_sr: RTL and testbench
================================

# mux_addsub_sr

Parametrised serial-operand adder/subtractor with shift-register result output. Reads two WIDTH-bit operands through LANES external 8:1-style multiplexers (shared select bus `sel_AnB`) and adds or subtracts them. It then shifts the WIDTH-bit result MSB-first into an external 74HC595-style chain (`SRCLK`/`SER`/`RCLK`). It is the generalised successor of the fixed 32-bit mux/CLA/tx top level: width, lane count, settle time and shift rate are configurable, and it adds a subtract mode.

## Interface
- `WIDTH`, 32, operand/result width; must be a multiple of `LANES`, elaboration error otherwise.
- `LANES`, 4, number of external mux lanes per operand.
- `SETTLE`, 2, idle cycles after each `sel_AnB` change before sampling; ≥1.
- `SR_DIV`, 1, clk cycles per SRCLK/RCLK half-period; ≥1.
- Derived: `DEPTH = WIDTH/LANES`, `SEL_W = max(1, clog2(DEPTH))`.

Ports:
- `clk`, in, 1, single clock; all state on rising edge.
- `rst_n`, in, 1, asynchronous active-low reset.
- `start`, in, 1, asynchronous request; a rising edge launches one operation.
- `sub`, in, 1, mode select sampled at launch: 0 = A+B, 1 = A−B.
- `a_lane`, in, LANES, mux outputs for operand A.
- `b_lane`, in, LANES, mux outputs for operand B.
- `sel_AnB`, out, SEL_W, shared mux select.
- `busy`, out, 1, operation in progress.
- `finish`, out, 1, one-cycle done pulse.
- `Cout`, out, 1, carry out; in subtract mode 1 = no borrow.
- `SRCLK`, out, 1, shift clock.
- `SER`, out, 1, serial data.
- `RCLK`, out, 1, storage/latch clock.

## Operation
- `start` passes through two flops (`start_d1`, `start_d2`). Launch is `start_d1 & ~start_d2`, accepted only in IDLE.
- FSM states: IDLE → CAPTURE → ADD → SHIFT → LATCH → DONE → IDLE.
- **IDLE:** `sel_AnB = 0`, `busy = 0`. On launch, register `sub`, set k=0, go to CAPTURE.
- **CAPTURE:** drive `sel_AnB = k`. Wait SETTLE cycles, then on the next cycle store `A[l*DEPTH+k] = a_lane[l]` and `B[l*DEPTH+k] = b_lane[l]` for every lane l. After k = DEPTH−1, go to ADD; otherwise increment k.
- **ADD:** single cycle. `{Cout, sum} = A + (B ^ {WIDTH{sub}}) + sub`, computed at WIDTH+1 bits. Cout holds its value until the next ADD.
- **SHIFT:** for bit i = WIDTH−1 down to 0:
  - Present `SER = sum[i]` with `SRCLK` low for SR_DIV cycles.
  - Then drive `SRCLK` high for SR_DIV cycles.
  - `SER` remains stable throughout the high phase.
- **LATCH:** `SRCLK = 0`, `RCLK` high for SR_DIV cycles, then low.
- **DONE:** `finish = 1` for exactly one cycle, `busy` deasserts in the same cycle, then IDLE.
- Launches arriving while not in IDLE are discarded, not queued. Holding `start` high produces exactly one operation.
- Reset at any point, including mid-shift, immediately returns every output to its reset value and the FSM to IDLE. The partial chain contents are not latched.

## Timing
- Reset values: `sel_AnB = 0`, `busy = 0`, `finish = 0`, `Cout = 0`, `SRCLK = 0`, `SER = 0`, `RCLK = 0`.
- Launch fires at the second clock edge after `start` rises. `busy` goes to 1 on that same edge.
- Cycles from `busy` rising to `finish` high: `DEPTH*(SETTLE+1) + 1 + 2*SR_DIV*WIDTH + 2*SR_DIV`.
  - Defaults: 24 + 1 + 64 + 2 = 91.
- `finish` is high in the cycle `busy` is first low. The next launch can be accepted on the following cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `MUX_ADDSUB_SUB_EN` defined: `sub` is sampled and subtract mode operates as specified.
- Not defined: the `sub` port remains but is ignored, the registered mode is forced to 0 (add only), and the B-inversion logic is removed.

## Test plan
- Reset mid-SHIFT (bit 15) → all outputs 0 the same cycle. A subsequent `start` edge runs a full, correct operation.
- Defaults, A = 0xFFFFFFFF, B = 0x00000001, sub = 0:
  - Chain receives 0x00000000 MSB-first, `Cout` = 1.
  - `finish` 91 cycles after `busy` rises.
  - 32 SRCLK rising edges, then 1 RCLK pulse.
- Defaults, `MUX_ADDSUB_SUB_EN` defined, A = 5, B = 7, sub = 1 → sum 0xFFFFFFFE, `Cout` = 0.
  - Same inputs without the macro → sum 0x0000000C, `Cout` = 0.
- `sel_AnB` sequencing:
  - Mux model returns `A[l*8+sel]`; check `sel_AnB` steps 0..7, each held 3 cycles.
  - A = 0x12345678 is reassembled exactly, proving lane/bit mapping.
- `start` held high for 200 cycles → exactly one `finish` pulse.
  - A second `start` edge during SHIFT → ignored, with no second operation.
- WIDTH = 16, LANES = 2, SETTLE = 1, SR_DIV = 3, A = 0x8000, B = 0x8000:
  - sum 0x0000, `Cout` = 1.
  - `sel_AnB` 3 bits stepping 0..7.
  - SRCLK period 6 cycles.
  - Latency 8*2 + 1 + 96 + 6 = 119.

Source files
------------

// File: rtl/mux_addsub_sr.sv
// -----------------------------------------------------------------------------
// mux_addsub_sr
//
// Serial-operand adder/subtractor with a 74HC595-style shift-register output.
// Operands A and B arrive through LANES external multiplexers per operand that
// share one select bus. For each select value k, lane l carries bit
// l*DEPTH+k. After capture, the WIDTH-bit result is computed in a single cycle.
// It is then shifted MSB-first on SRCLK/SER and latched with one RCLK pulse.
//
// Optional feature macro: MUX_ADDSUB_SUB_EN
//   defined   : 'sub' is sampled at launch and selects A-B.
//   undefined : 'sub' is ignored and the block only computes A+B.
//
// Parameters:
//   WIDTH  operand/result width; must be a multiple of LANES
//   LANES  external mux lanes per operand
//   SETTLE idle cycles after each select change before sampling (>= 1)
//   SR_DIV clk cycles per SRCLK/RCLK half-period (>= 1)
//
// Ports:
//   clk      in   single clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   asynchronous request; a rising edge launches one operation
//   sub      in   mode at launch: 0 = A+B, 1 = A-B
//   a_lane   in   [LANES] mux outputs for operand A
//   b_lane   in   [LANES] mux outputs for operand B
//   sel_AnB  out  [SEL_W] shared mux select
//   busy     out  operation in progress
//   finish   out  one-cycle completion pulse
//   Cout     out  carry out (subtract: 1 = no borrow)
//   SRCLK    out  shift clock
//   SER      out  serial data
//   RCLK     out  storage/latch clock
// -----------------------------------------------------------------------------
module mux_addsub_sr #(
   parameter int WIDTH  = 32,
   parameter int LANES  = 4,
   parameter int SETTLE = 2,
   parameter int SR_DIV = 1,
   localparam int DEPTH = WIDTH / LANES,
   localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [LANES-1:0] a_lane,
   input  logic [LANES-1:0] b_lane,
   output logic [SEL_W-1:0] sel_AnB,
   output logic             busy,
   output logic             finish,
   output logic             Cout,
   output logic             SRCLK,
   output logic             SER,
   output logic             RCLK
);

   localparam int BIT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int CNT_MAX = (SETTLE > (SR_DIV - 1)) ? SETTLE : (SR_DIV - 1);
   localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

   localparam logic [SEL_W-1:0] K_LAST     = SEL_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SETTLE);
   localparam logic [CNT_W-1:0] CNT_DIV    = CNT_W'(SR_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WIDTH - 1);

   // Elaboration-time parameter sanity checks
   generate
      if ((WIDTH % LANES) != 0) begin : g_err_width
         $error("mux_addsub_sr: WIDTH must be a multiple of LANES");
      end
      if (SETTLE < 1) begin : g_err_settle
         $error("mux_addsub_sr: SETTLE must be at least 1");
      end
      if (SR_DIV < 1) begin : g_err_div
         $error("mux_addsub_sr: SR_DIV must be at least 1");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CAPTURE = 3'd1,
      S_ADD     = 3'd2,
      S_SHIFT   = 3'd3,
      S_LATCH   = 3'd4,
      S_DONE    = 3'd5
   } state_e;

   state_e                        state_q, state_d;
   logic                          start_d1_q, start_d2_q;
   logic [SEL_W-1:0]              k_q, k_d;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic [BIT_W-1:0]              bit_q, bit_d;
   logic                          phase_q, phase_d;
   // Operands stored lane-major: bit [l][k] is operand bit l*DEPTH+k.
   logic [LANES-1:0][DEPTH-1:0]   a_q, a_d;
   logic [LANES-1:0][DEPTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]              sum_q, sum_d;
   logic [SEL_W-1:0]              sel_q, sel_d;
   logic                          busy_q, busy_d;
   logic                          finish_q, finish_d;
   logic                          cout_q, cout_d;
   logic                          srclk_q, srclk_d;
   logic                          ser_q, ser_d;
   logic                          rclk_q, rclk_d;
   logic                          launch_s;
   logic [WIDTH:0]                add_s;

`ifdef MUX_ADDSUB_SUB_EN
   logic                          sub_q, sub_d;

   // Two's-complement add/subtract: invert B and inject the mode as carry-in.
   function automatic logic [WIDTH:0] add_sub(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             s);
      logic [WIDTH-1:0] b_eff;
      b_eff   = b ^ {WIDTH{s}};
      add_sub = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, s};
   endfunction

   assign add_s = add_sub(a_q, b_q, sub_q);
`else
   logic                          sub_unused_s;

   function automatic logic [WIDTH:0] add_only(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      add_only = {1'b0, a} + {1'b0, b};
   endfunction

   assign sub_unused_s = sub;
   assign add_s        = add_only(a_q, b_q);
`endif

   // Rising edge of the two-flop synchronised start request
   assign launch_s = start_d1_q & ~start_d2_q;

   // Next-state and next-output logic for the operation sequencer
   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      phase_d  = phase_q;
      a_d      = a_q;
      b_d      = b_q;
      sum_d    = sum_q;
      sel_d    = sel_q;
      busy_d   = busy_q;
      finish_d = 1'b0;
      cout_d   = cout_q;
      srclk_d  = srclk_q;
      ser_d    = ser_q;
      rclk_d   = rclk_q;
`ifdef MUX_ADDSUB_SUB_EN
      sub_d    = sub_q;
`endif

      case (state_q)
         S_IDLE: begin
            sel_d   = '0;
            srclk_d = 1'b0;
            rclk_d  = 1'b0;
            if (launch_s) begin
`ifdef MUX_ADDSUB_SUB_EN
               sub_d   = sub;
`endif
               k_d     = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_CAPTURE;
            end else begin
               busy_d  = 1'b0;
            end
         end

         S_CAPTURE: begin
            // cnt counts the settle cycles; the sample happens when it reaches SETTLE.
            if (cnt_q == CNT_SETTLE) begin
               for (int l = 0; l < LANES; l++) begin
                  a_d[l][k_q] = a_lane[l];
                  b_d[l][k_q] = b_lane[l];
               end
               cnt_d = '0;
               if (k_q == K_LAST) begin
                  sel_d   = '0;
                  state_d = S_ADD;
               end else begin
                  k_d     = k_q + SEL_W'(1);
                  sel_d   = k_q + SEL_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_ADD: begin
            // The MSB is presented on SER on the same edge that stores the sum.
            sum_d   = add_s[WIDTH-1:0];
            cout_d  = add_s[WIDTH];
            ser_d   = add_s[WIDTH-1];
            bit_d   = BIT_LAST;
            cnt_d   = '0;
            phase_d = 1'b0;
            srclk_d = 1'b0;
            state_d = S_SHIFT;
         end

         S_SHIFT: begin
            if (cnt_q == CNT_DIV) begin
               cnt_d = '0;
               if (!phase_q) begin
                  phase_d = 1'b1;
                  srclk_d = 1'b1;
               end else begin
                  phase_d = 1'b0;
                  srclk_d = 1'b0;
                  if (bit_q == '0) begin
                     ser_d   = 1'b0;
                     rclk_d  = 1'b1;
                     state_d = S_LATCH;
                  end else begin
                     bit_d   = bit_q - BIT_W'(1);
                     ser_d   = sum_q[bit_q - BIT_W'(1)];
                  end
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_LATCH: begin
            // phase 0: RCLK high; phase 1: RCLK low; each SR_DIV cycles.
            if (cnt_q == CNT_DIV) begin
               cnt_d = '0;
               if (!phase_q) begin
                  phase_d = 1'b1;
                  rclk_d  = 1'b0;
               end else begin
                  phase_d  = 1'b0;
                  busy_d   = 1'b0;
                  finish_d = 1'b1;
                  state_d  = S_DONE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
            sel_d   = '0;
            busy_d  = 1'b0;
            srclk_d = 1'b0;
            ser_d   = 1'b0;
            rclk_d  = 1'b0;
         end
      endcase
   end

   // Sequencer state, operand/result storage and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         start_d1_q <= 1'b0;
         start_d2_q <= 1'b0;
         k_q        <= '0;
         cnt_q      <= '0;
         bit_q      <= '0;
         phase_q    <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         sum_q      <= '0;
         sel_q      <= '0;
         busy_q     <= 1'b0;
         finish_q   <= 1'b0;
         cout_q     <= 1'b0;
         srclk_q    <= 1'b0;
         ser_q      <= 1'b0;
         rclk_q     <= 1'b0;
`ifdef MUX_ADDSUB_SUB_EN
         sub_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         start_d1_q <= start;
         start_d2_q <= start_d1_q;
         k_q        <= k_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         phase_q    <= phase_d;
         a_q        <= a_d;
         b_q        <= b_d;
         sum_q      <= sum_d;
         sel_q      <= sel_d;
         busy_q     <= busy_d;
         finish_q   <= finish_d;
         cout_q     <= cout_d;
         srclk_q    <= srclk_d;
         ser_q      <= ser_d;
         rclk_q     <= rclk_d;
`ifdef MUX_ADDSUB_SUB_EN
         sub_q      <= sub_d;
`endif
      end
   end

   assign sel_AnB = sel_q;
   assign busy    = busy_q;
   assign finish  = finish_q;
   assign Cout    = cout_q;
   assign SRCLK   = srclk_q;
   assign SER     = ser_q;
   assign RCLK    = rclk_q;

endmodule

// File: tb/tb_mux_addsub_sr.sv
// -----------------------------------------------------------------------------
// tb_mux_addsub_sr
//
// Bench for mux_addsub_sr with two instances:
//   unit 0: default parameters (32-bit, 4 lanes, SETTLE 2, SR_DIV 1)
//   unit 1: 16-bit, 2 lanes, SETTLE 1, SR_DIV 3
// External muxes are modelled behaviourally from the operand under test.
// The shift-register chain is reconstructed from SER on each SRCLK rising edge.
// Results are compared with plain modular arithmetic.
// -----------------------------------------------------------------------------
module tb_mux_addsub_sr;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start  [2];
   logic       sub    [2];
   logic [3:0] a_lane [2];
   logic [3:0] b_lane [2];
   logic [2:0] sel    [2];
   logic       busy   [2];
   logic       finish [2];
   logic       cout   [2];
   logic       srclk  [2];
   logic       ser    [2];
   logic       rclk   [2];
   logic [31:0] opa   [2];
   logic [31:0] opb   [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mux_addsub_sr u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .sub(sub[0]),
      .a_lane(a_lane[0]), .b_lane(b_lane[0]), .sel_AnB(sel[0]),
      .busy(busy[0]), .finish(finish[0]), .Cout(cout[0]),
      .SRCLK(srclk[0]), .SER(ser[0]), .RCLK(rclk[0])
   );

   mux_addsub_sr #(.WIDTH(16), .LANES(2), .SETTLE(1), .SR_DIV(3)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .sub(sub[1]),
      .a_lane(a_lane[1][1:0]), .b_lane(b_lane[1][1:0]), .sel_AnB(sel[1]),
      .busy(busy[1]), .finish(finish[1]), .Cout(cout[1]),
      .SRCLK(srclk[1]), .SER(ser[1]), .RCLK(rclk[1])
   );

   function automatic int w_of(int u);     return (u == 0) ? 32 : 16; endfunction
   function automatic int lanes_of(int u); return (u == 0) ? 4 : 2;   endfunction
   function automatic int st_of(int u);    return (u == 0) ? 2 : 1;   endfunction
   function automatic int div_of(int u);   return (u == 0) ? 1 : 3;   endfunction

   // External mux model: lane l returns operand bit l*8 + select (DEPTH is 8 in both units)
   always_comb begin
      for (int u = 0; u < 2; u++) begin
         a_lane[u] = 4'd0;
         b_lane[u] = 4'd0;
         for (int l = 0; l < 4; l++) begin
            if (l < lanes_of(u)) begin
               a_lane[u][l] = opa[u][l * 8 + int'(sel[u])];
               b_lane[u][l] = opb[u][l * 8 + int'(sel[u])];
            end
         end
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // mode: 0 normal, 1 hold start high, 2 extra start edge during SHIFT, 3 reset mid-SHIFT
   task automatic run_op(input int u, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input int mode);
      int w, st, dv, lat, n, c, ns, nr, rhigh, last_rise, bad_sel, bad_per, bad_stab, extra;
      logic [63:0] mask, tot;
      logic [31:0] chain, exp_sum;
      logic exp_cout, eff_sub, prev_sr, prev_rc, ser_at_rise, done;
      w  = w_of(u);
      st = st_of(u);
      dv = div_of(u);
      lat = 8 * (st + 1) + 1 + 2 * dv * w + 2 * dv;
      mask = (64'd1 << w) - 64'd1;
`ifdef MUX_ADDSUB_SUB_EN
      eff_sub = s;
`else
      eff_sub = 1'b0;
`endif
      if (eff_sub) begin
         tot      = ({32'd0, a} - {32'd0, b}) & mask;
         exp_sum  = tot[31:0];
         exp_cout = ({32'd0, a} >= {32'd0, b});
      end else begin
         tot      = {32'd0, a} + {32'd0, b};
         exp_sum  = 32'(tot & mask);
         exp_cout = tot[w];
      end
      opa[u] = a;
      opb[u] = b;
      sub[u] = s;
      @(negedge clk);
      start[u] = 1'b1;
      n = 0;
      done = 1'b0;
      while (!done && n < 10) begin
         @(posedge clk); #1;
         n++;
         if (busy[u] === 1'b1) done = 1'b1;
      end
      check_eq("launch_edge", 64'(n), 64'd2);
      if (mode != 1) start[u] = 1'b0;

      c = 0; ns = 0; nr = 0; rhigh = 0; last_rise = -1;
      bad_sel = 0; bad_per = 0; bad_stab = 0;
      chain = 32'd0; prev_sr = 1'b0; prev_rc = 1'b0; ser_at_rise = 1'b0;
      done = 1'b0;
      while (!done && c < 400) begin
         if (c < 8 * (st + 1) && sel[u] !== 3'(c / (st + 1))) bad_sel++;
         if (srclk[u] === 1'b1 && !prev_sr) begin
            ns++;
            chain = {chain[30:0], ser[u]};
            ser_at_rise = ser[u];
            if (last_rise >= 0 && (c - last_rise) != 2 * dv) bad_per++;
            last_rise = c;
         end
         if (srclk[u] === 1'b1 && ser[u] !== ser_at_rise) bad_stab++;
         if (rclk[u] === 1'b1) rhigh++;
         if (rclk[u] === 1'b1 && !prev_rc) begin
            nr++;
            check_eq("srclk_before_rclk", 64'(ns), 64'(w));
         end
         prev_sr = srclk[u];
         prev_rc = rclk[u];
         if (mode == 2) start[u] = (ns >= 5 && ns < 8);
         if (mode == 3 && ns == w - 16 + 16 - (w - 16) && srclk[u] === 1'b0) begin
            // 16 bits shifted, bit 15 now presented: pull reset mid-cycle
            #2 rst_n = 1'b0;
            #1 check_eq("reset_mid_shift_outs",
                        {sel[u], busy[u], finish[u], cout[u], srclk[u], ser[u], rclk[u]}, 64'd0);
            #2 rst_n = 1'b1;
            return;
         end
         if (finish[u] === 1'b1) begin
            done = 1'b1;
         end else begin
            @(posedge clk); #1;
            c++;
         end
      end
      check_eq("latency", 64'(c), 64'(lat));
      check_eq("busy_low_at_finish", 64'(busy[u]), 64'd0);
      check_eq("chain_sum", 64'(chain) & mask, 64'(exp_sum));
      check_eq("cout", 64'(cout[u]), 64'(exp_cout));
      check_eq("srclk_edges", 64'(ns), 64'(w));
      check_eq("rclk_pulses", 64'(nr), 64'd1);
      check_eq("rclk_width", 64'(rhigh), 64'(dv));
      check_eq("sel_sequence_errs", 64'(bad_sel), 64'd0);
      check_eq("srclk_period_errs", 64'(bad_per), 64'd0);
      check_eq("ser_stable_errs", 64'(bad_stab), 64'd0);
      @(posedge clk); #1;
      check_eq("finish_one_cycle", 64'(finish[u]), 64'd0);
      if (mode == 1 || mode == 2) begin
         extra = 0;
         for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (finish[u] === 1'b1 || busy[u] === 1'b1) extra++;
         end
         check_eq("no_second_operation", 64'(extra), 64'd0);
      end
      start[u] = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   initial begin
      logic [31:0] ra, rb;
      rst_n = 1'b0;
      for (int u = 0; u < 2; u++) begin
         start[u] = 1'b0; sub[u] = 1'b0; opa[u] = 32'd0; opb[u] = 32'd0;
      end
      #23 rst_n = 1'b1;
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         check_eq("reset_outs",
                  {sel[u], busy[u], finish[u], cout[u], srclk[u], ser[u], rclk[u]}, 64'd0);
      end

      run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
      run_op(0, 32'd5, 32'd7, 1'b1, 0);
      run_op(0, 32'h1234_5678, 32'd0, 1'b0, 0);
      run_op(0, $urandom, $urandom, 1'b1, 1);
      run_op(0, $urandom, $urandom, 1'b0, 2);
      run_op(0, $urandom, $urandom, 1'b1, 3);
      repeat (2) @(posedge clk);
      run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
      for (int i = 0; i < 5; i++) begin
         ra = $urandom;
         rb = $urandom;
         run_op(0, ra, rb, 1'($urandom_range(1, 0)), 0);
      end

      run_op(1, 32'h0000_8000, 32'h0000_8000, 1'b0, 0);
      for (int i = 0; i < 3; i++) begin
         ra = $urandom & 32'h0000_FFFF;
         rb = $urandom & 32'h0000_FFFF;
         run_op(1, ra, rb, 1'($urandom_range(1, 0)), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
